uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources.
//  Accepts one byte per grant and drives P_DATA/Data_Valid/PAR_EN/PAR_TYP into the
//  UART TX top. Uses the TX busy output to sequence frames back-to-back.
//  Pulses a per-requester done when that frame's stop bit completes.
// PARAMETERS
//  NUM_REQ      4    number of requesters (2..8)
//  DATA_W       8    byte width; must match TX P_DATA
//  TIMEOUT_CYC  1024 watchdog limit in clk cycles; used only with UART_TX_ARB_TIMEOUT_EN
// PORTS
//  clk          in   1               system clock, rising edge
//  rst          in   1               async reset, active-high
//  req          in   NUM_REQ         level request per source; data must be valid while high
//  req_data     in   NUM_REQ*DATA_W  source i byte in bits [i*DATA_W +: DATA_W]
//  req_par_en   in   NUM_REQ         parity enable per source
//  req_par_typ  in   NUM_REQ         parity type per source (0 even, 1 odd)
//  gnt          out  NUM_REQ         one-hot, 1-cycle pulse: byte captured from source i
//  done         out  NUM_REQ         one-hot, 1-cycle pulse: source i frame fully sent
//  P_DATA       out  DATA_W          byte to TX, stable from grant until done
//  Data_Valid   out  1               launch strobe to TX
//  PAR_EN       out  1               latched parity enable for current frame
//  PAR_TYP      out  1               latched parity type for current frame
//  tx_busy      in   1               TX busy flag
//  timeout_err  out  1               1-cycle abort pulse (tied 0 without macro)
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, state IDLE, rr_ptr=0, watchdog=0.
//  FSM: IDLE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE: if |req, winner = first set bit at/after rr_ptr, wrapping NUM_REQ-1 -> 0.
//   Next edge: gnt[w]=1 (one cycle); P_DATA, PAR_EN, PAR_TYP loaded from w;
//   Data_Valid=1; cur_id=w; state WAIT_BUSY. No req: all outputs hold, stay IDLE.
//  WAIT_BUSY: Data_Valid held 1 until tx_busy sampled 1.
//   That edge: Data_Valid=0, state WAIT_DONE.
//  WAIT_DONE: on tx_busy sampled 0: done[cur_id]=1 (one cycle),
//   rr_ptr=(cur_id+1) mod NUM_REQ, state IDLE.
//  Latency: req in IDLE -> gnt and Data_Valid 1 cycle later.
//   tx_busy falling -> done 1 cycle later. Next grant is 1 cycle after done.
//  Requests are sampled only in IDLE. req changes during a frame have no effect.
//   P_DATA/PAR_* stay frozen from grant until the next grant.
//  A source still high after its done is re-eligible but ranks last (fairness).
//   One source alone gets consecutive grants.
//  gnt and done are never asserted in the same cycle.
//   At most one bit of each is set.
//  Reset mid-frame: frame is dropped with no done pulse.
//   The TX shares rst, so it aborts too.
// CONFIGURATION
//  UART_TX_ARB_TIMEOUT_EN defined:
//   - 10-bit watchdog clears on entry to WAIT_BUSY and on entry to WAIT_DONE.
//   - It increments each cycle in those states.
//   - When it reaches TIMEOUT_CYC-1: timeout_err=1 (one cycle), Data_Valid=0,
//     no done pulse, rr_ptr=(cur_id+1) mod NUM_REQ, state IDLE.
//   - The abort takes priority over a tx_busy event in the same cycle.
//  Not defined: no watchdog; FSM waits indefinitely; timeout_err is constant 0.
// TESTING
//  1. Reset, then req=4'b0001, data0=8'hA5, par_en0=1, typ0=0
//     -> gnt=0001 next cycle, P_DATA=A5, PAR_EN=1, Data_Valid until busy, done=0001 once.
//  2. req=4'b1111 held, data i=8'h10+i
//     -> grant order 0,1,2,3,0; each gnt follows previous done by 1 cycle.
//  3. req=4'b1010 with rr_ptr=2 -> gnt=1000, then gnt=0010.
//  4. Assert rst mid WAIT_DONE -> all outputs 0 at once; no done; first grant after reset starts from source 0.
//  5. Macro on, TIMEOUT_CYC=16, tx_busy stuck 0
//     -> timeout_err 16 cycles after gnt; Data_Valid=0; no done; next grant goes to the next source.
//  6. req toggles 0 during WAIT_BUSY -> frame still completes; P_DATA unchanged; done pulses.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte sources, the round-robin arbiter and the UART TX top.
// The master modport is the arbiter side; the slave modport is the sources plus TX side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  // Handshake: req[i] is a level valid and req_data/par_* must hold while it is high.
  // gnt[i] pulses on the cycle the byte is captured. Data_Valid is held until tx_busy
  // is seen high. done[i] pulses once tx_busy falls again after that frame.
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_par_en;
  logic [NUM_REQ-1:0]        req_par_typ;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         P_DATA;
  logic                      Data_Valid;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic                      tx_busy;
  logic                      timeout_err;

  modport master (
    input  req, req_data, req_par_en, req_par_typ, tx_busy,
    output gnt, done, P_DATA, Data_Valid, PAR_EN, PAR_TYP, timeout_err
  );

  modport slave (
    output req, req_data, req_par_en, req_par_typ, tx_busy,
    input  gnt, done, P_DATA, Data_Valid, PAR_EN, PAR_TYP, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_TX_ARB_TIMEOUT_EN to add the per-frame watchdog that drives timeout_err.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_arbiter_if.master    bus,
  output logic [1:0]           state_o
);
  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 1024) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0]   p_data_q, p_data_d;
  logic                dv_q, dv_d;
  logic                par_en_q, par_en_d;
  logic                par_typ_q, par_typ_d;
  logic [ID_W-1:0]     cur_id_q, cur_id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     scan_id;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    return (v == ID_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // Scan starts at rr_ptr so the source served last ranks lowest next time.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && bus.req[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
      scan_id = wrap_inc(scan_id);
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT_CYC - 1);
  logic [9:0] wd_q, wd_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    done_d    = '0;
    p_data_d  = p_data_q;
    dv_d      = dv_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    cur_id_d  = cur_id_q;
    rr_ptr_d  = rr_ptr_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    timeout_d = 1'b0;
    wd_d      = (state_q == IDLE) ? '0 : wd_q + 10'd1;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d[win_id] = 1'b1;
          p_data_d      = bus.req_data[int'(win_id)*DATA_W +: DATA_W];
          par_en_d      = bus.req_par_en[win_id];
          par_typ_d     = bus.req_par_typ[win_id];
          dv_d          = 1'b1;
          cur_id_d      = win_id;
          state_d       = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          dv_d    = 1'b0;
          state_d = WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          done_d[cur_id_q] = 1'b1;
          rr_ptr_d         = wrap_inc(cur_id_q);
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
    // Abort wins over any tx_busy event seen on the same edge.
    if ((state_q == WAIT_BUSY || state_q == WAIT_DONE) && wd_q == WD_LAST) begin
      state_d   = IDLE;
      dv_d      = 1'b0;
      done_d    = '0;
      timeout_d = 1'b1;
      rr_ptr_d  = wrap_inc(cur_id_q);
      wd_d      = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      cur_id_q  <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      p_data_q  <= p_data_d;
      dv_q      <= dv_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      cur_id_q  <= cur_id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.P_DATA     = p_data_q;
  assign bus.Data_Valid = dv_q;
  assign bus.PAR_EN     = par_en_q;
  assign bus.PAR_TYP    = par_typ_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the bench itself plays the UART TX busy flag.
// Builds with or without UART_TX_ARB_TIMEOUT_EN (watchdog shortened to 16 cycles).
module tb_uart_tx_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] st;
  int         n_checks = 0;
  int         n_fail   = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [7:0] d, input logic pe, input logic pt);
    bus.req_data[i*8 +: 8] = d;
    bus.req_par_en[i]      = pe;
    bus.req_par_typ[i]     = pt;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},  32'(bus.gnt), 32'h0);
    chk({tag, "_done"}, 32'(bus.done), 32'h0);
    chk({tag, "_pdata"}, 32'(bus.P_DATA), 32'h0);
    chk({tag, "_dv"},   32'(bus.Data_Valid), 32'h0);
    chk({tag, "_paren"}, 32'(bus.PAR_EN), 32'h0);
    chk({tag, "_partyp"}, 32'(bus.PAR_TYP), 32'h0);
    chk({tag, "_tmo"},  32'(bus.timeout_err), 32'h0);
    chk({tag, "_state"}, 32'(st), 32'h0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    chk_all_zero("reset");
    tick;
    rst = 1'b0;
  endtask

  // One full frame: grant, Data_Valid until busy, busy for three cycles, then done.
  task automatic run_frame(input int id, input logic [7:0] d, input logic pe, input logic pt,
                           input bit drop);
    tick;
    chk("gnt", 32'(bus.gnt), 32'(1) << id);
    chk("dv_at_gnt", 32'(bus.Data_Valid), 32'h1);
    chk("pdata_at_gnt", 32'(bus.P_DATA), 32'(d));
    chk("paren", 32'(bus.PAR_EN), 32'(pe));
    chk("partyp", 32'(bus.PAR_TYP), 32'(pt));
    chk("done_at_gnt", 32'(bus.done), 32'h0);
    chk("tmo_at_gnt", 32'(bus.timeout_err), 32'h0);
    chk("state_wait_busy", 32'(st), 32'h1);
    if (drop) begin
      bus.req      = '0;
      bus.req_data = '1;
    end
    tick;
    chk("gnt_pulse", 32'(bus.gnt), 32'h0);
    chk("dv_hold", 32'(bus.Data_Valid), 32'h1);
    bus.tx_busy = 1'b1;
    tick;
    chk("dv_drop", 32'(bus.Data_Valid), 32'h0);
    chk("state_wait_done", 32'(st), 32'h2);
    tick;
    tick;
    chk("done_early", 32'(bus.done), 32'h0);
    chk("pdata_frozen", 32'(bus.P_DATA), 32'(d));
    bus.tx_busy = 1'b0;
    tick;
    chk("done", 32'(bus.done), 32'(1) << id);
    chk("gnt_at_done", 32'(bus.gnt), 32'h0);
    chk("state_idle", 32'(st), 32'h0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_done_excl", 32'(|bus.gnt && |bus.done), 32'h0);
      chk("onehot0", 32'(!$onehot0(bus.gnt) || !$onehot0(bus.done)), 32'h0);
    end
  end

  initial begin
    bus.req         = '0;
    bus.req_data    = '0;
    bus.req_par_en  = '0;
    bus.req_par_typ = '0;
    bus.tx_busy     = 1'b0;

    // Single source, then confirm done came only once.
    do_reset;
    set_src(0, 8'hA5, 1'b1, 1'b0);
    bus.req = 4'b0001;
    run_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0);
    bus.req = 4'b0000;
    tick;
    chk("t1_no_regrant", 32'(bus.gnt), 32'h0);
    chk("t1_done_once", 32'(bus.done), 32'h0);

    // All four requesting: rotation 0,1,2,3,0 back-to-back.
    do_reset;
    for (int i = 0; i < 4; i++)
      set_src(i, 8'h10 + 8'(i), ((4'b0101 >> i) & 4'h1) != 0, ((4'b0011 >> i) & 4'h1) != 0);
    bus.req = 4'b1111;
    run_frame(0, 8'h10, 1'b1, 1'b1, 1'b0);
    run_frame(1, 8'h11, 1'b0, 1'b1, 1'b0);
    run_frame(2, 8'h12, 1'b1, 1'b0, 1'b0);
    run_frame(3, 8'h13, 1'b0, 1'b0, 1'b0);
    run_frame(0, 8'h10, 1'b1, 1'b1, 1'b0);

    // Move rr_ptr to 2, then req=1010 must serve 3 before 1.
    bus.req = 4'b0010;
    run_frame(1, 8'h11, 1'b0, 1'b1, 1'b0);
    bus.req = 4'b1010;
    run_frame(3, 8'h13, 1'b0, 1'b0, 1'b0);
    run_frame(1, 8'h11, 1'b0, 1'b1, 1'b0);

    // Reset in WAIT_DONE: outputs clear at once, no done, pointer back to 0.
    bus.req = 4'b0100;
    tick;
    chk("t4_gnt", 32'(bus.gnt), 32'h4);
    bus.tx_busy = 1'b1;
    tick;
    chk("t4_state", 32'(st), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("t4_async");
    bus.tx_busy = 1'b0;
    tick;
    chk("t4_no_done", 32'(bus.done), 32'h0);
    bus.req = 4'b0101;
    rst = 1'b0;
    run_frame(0, 8'h10, 1'b1, 1'b1, 1'b0);

    // Request withdrawn and data scrambled mid-frame: frame still completes.
    set_src(3, 8'h5C, 1'b1, 1'b1);
    bus.req = 4'b1000;
    run_frame(3, 8'h5C, 1'b1, 1'b1, 1'b1);

    set_src(0, 8'h77, 1'b0, 1'b0);
    set_src(1, 8'h88, 1'b1, 1'b0);
`ifdef UART_TX_ARB_TIMEOUT_EN
    // tx_busy never rises: watchdog aborts 16 cycles after the grant.
    bus.req = 4'b0011;
    tick;
    chk("t5_gnt", 32'(bus.gnt), 32'h1);
    repeat (15) tick;
    chk("t5_tmo_early", 32'(bus.timeout_err), 32'h0);
    chk("t5_dv_early", 32'(bus.Data_Valid), 32'h1);
    tick;
    chk("t5_tmo", 32'(bus.timeout_err), 32'h1);
    chk("t5_dv", 32'(bus.Data_Valid), 32'h0);
    chk("t5_no_done", 32'(bus.done), 32'h0);
    chk("t5_state", 32'(st), 32'h0);
    run_frame(1, 8'h88, 1'b1, 1'b0, 1'b0);
    bus.req = 4'b0000;
`else
    // Without the watchdog the arbiter waits on tx_busy indefinitely.
    bus.req = 4'b0001;
    tick;
    chk("t5_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    repeat (20) tick;
    chk("t5_dv_wait", 32'(bus.Data_Valid), 32'h1);
    chk("t5_tmo_zero", 32'(bus.timeout_err), 32'h0);
    chk("t5_state", 32'(st), 32'h1);
    bus.tx_busy = 1'b1;
    tick;
    bus.tx_busy = 1'b0;
    tick;
    chk("t5_done", 32'(bus.done), 32'h1);
`endif
    tick;
    chk("final_idle_gnt", 32'(bus.gnt), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
